// File: rtl/hyper_bridge_pkg.sv
// hyper_bridge_pkg: command codes, error codes and FSM states
// shared by the UART-to-HyperRAM command bridge.
package hyper_bridge_pkg;

    localparam logic [7:0] CMD_ADDR     = 8'h01;
    localparam logic [7:0] CMD_LOAD     = 8'h02;
    localparam logic [7:0] CMD_WRITE    = 8'h03;
    localparam logic [7:0] CMD_READ     = 8'h04;
    localparam logic [7:0] CMD_READ_REQ = 8'h05;
    localparam logic [7:0] CMD_COUNT    = 8'h06;
    localparam logic [7:0] CMD_CONST    = 8'h07;
    localparam logic [7:0] CMD_STATUS   = 8'h08;

    localparam logic [7:0] ERR_NONE      = 8'd0;
    localparam logic [7:0] ERR_BAD_CMD   = 8'd1;
    localparam logic [7:0] ERR_BUSY_TMO  = 8'd2;
    localparam logic [7:0] ERR_OVERFLOW  = 8'd3;
    localparam logic [7:0] ERR_BURST_LEN = 8'd4;
    localparam logic [7:0] ERR_BAD_INDEX = 8'd5;
    localparam logic [7:0] ERR_TIMEOUT   = 8'd6;

    localparam logic [2:0] ST_RX        = 3'd0;
    localparam logic [2:0] ST_EXEC      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    function automatic int data_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/hyper_bridge_txser.sv
// hyper_bridge_txser: sends one DATA_W word MSB byte first over the
// tx_ready/tx_start handshake and pulses done_o after the last byte.
module hyper_bridge_txser
    import hyper_bridge_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              tx_ready_i,
    output logic              tx_start_o,
    output logic [7:0]        tx_data_o,
    output logic              done_o
);

    localparam int NB = data_bytes(DATA_W);
    localparam int CW = $clog2(NB + 1);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wlo_q, wlo_d;
    logic              start_q, start_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        wlo_d   = wlo_q;
        start_d = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        if (start_i) begin
            sh_d  = word_i;
            cnt_d = CW'(NB);
            wlo_d = 1'b0;
        end else if (cnt_q != '0) begin
            if (!wlo_q) begin
                if (tx_ready_i) begin
                    start_d = 1'b1;
                    data_d  = sh_q[DATA_W-1 -: 8];
                    wlo_d   = 1'b1;
                end
            end else if (!tx_ready_i && !start_q) begin
                // the UART has accepted the byte; move to the next one
                sh_d   = sh_q << 8;
                cnt_d  = cnt_q - 1'b1;
                wlo_d  = 1'b0;
                done_d = (cnt_q == CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            wlo_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            wlo_q   <= wlo_d;
            start_q <= start_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign tx_start_o = start_q;
    assign tx_data_o  = data_q;
    assign done_o     = done_q;

endmodule

// File: rtl/hyper_cmd_bridge.sv
// hyper_cmd_bridge: byte-serial command frames to hyper_xface requests.
// Define HYPER_BRIDGE_TIMEOUT_EN to drop stalled partial frames.
module hyper_cmd_bridge
    import hyper_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 8,
    parameter int BUSY_WAIT  = 16,
    parameter int CONST_WORD = 259
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    input  logic                   tx_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   rd_req,
    output logic                   wr_req,
    output logic [ADDR_W-1:0]      addr,
    output logic [DATA_W-1:0]      wr_d,
    output logic [DATA_W/8-1:0]    wr_byte_en,
    output logic [5:0]             rd_num_dwords,
    input  logic [DATA_W-1:0]      rd_d,
    input  logic                   rd_rdy,
    input  logic                   busy,
    output logic                   err
);

    localparam int NB  = data_bytes(DATA_W);
    localparam int FW  = 8 * (NB + 1);
    localparam int BCW = $clog2(NB + 1);
    localparam int IW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int BWW = $clog2(BUSY_WAIT + 1);

    logic [2:0]        st_q, st_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic [BCW-1:0]    bcnt_q, bcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wrd_q, wrd_d;
    logic [NB-1:0]     be_q, be_d;
    logic [5:0]        nd_q, nd_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [BWW-1:0]    bw_q, bw_d;
    logic              err_q, err_d;
    logic [7:0]        ecode_q, ecode_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic [15:0]       ovr_q, ovr_d;
    logic [7:0]        last_q, last_d;
    logic              rdr_q, rdr_d;
    logic              wrr_q, wrr_d;

    logic [DATA_W-1:0] rbuf_q [MAX_BURST];
    logic              rbuf_we;
    logic [IW-1:0]     rbuf_wi;
    logic              tx_go;
    logic [DATA_W-1:0] tx_word;
    logic              tx_done;
    logic [7:0]        wnext;
    logic [7:0]        code;

    wire [7:0]        cmd     = frame_q[FW-1 -: 8];
    wire [DATA_W-1:0] payload = frame_q[DATA_W-1:0];

    function automatic logic [DATA_W-1:0] fit32(input logic [31:0] w);
        return DATA_W'(w);
    endfunction

`ifdef HYPER_BRIDGE_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 2 ** 20;
    logic [20:0] tmo_q, tmo_d;
`endif

    always_comb begin
        st_d = st_q; frame_d = frame_q; bcnt_d = bcnt_q;
        addr_d = addr_q; wrd_d = wrd_q; be_d = be_q; nd_d = nd_q;
        wcnt_d = wcnt_q; bw_d = bw_q; err_d = err_q; ecode_d = ecode_q;
        cnt_d = cnt_q; ovr_d = ovr_q; last_d = last_q;
        rdr_d = 1'b0; wrr_d = 1'b0;
        tx_go = 1'b0; tx_word = '0;
        rbuf_we = 1'b0; rbuf_wi = '0;
        wnext = wcnt_q; code = ecode_q;
        if (rx_valid && st_q != ST_RX && ovr_q != 16'hFFFF)
            ovr_d = ovr_q + 16'd1;
        unique case (st_q)
            ST_RX: begin
                if (rx_valid) begin
                    frame_d = {frame_q[FW-9:0], rx_data};
                    if (bcnt_q == BCW'(NB)) begin
                        bcnt_d = '0;
                        st_d   = ST_EXEC;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                tx_go = 1'b1;
                st_d  = ST_RESP;
                unique case (cmd)
                    CMD_ADDR: begin
                        addr_d  = payload[ADDR_W-1:0];
                        tx_word = payload;
                    end
                    CMD_LOAD: begin
                        wrd_d   = payload;
                        tx_word = payload;
                    end
                    CMD_WRITE: begin
                        tx_go = 1'b0;
                        if (busy) begin
                            st_d = ST_EXEC;
                        end else begin
                            wrr_d  = 1'b1;
                            be_d   = (payload[NB-1:0] == '0) ? '1 : payload[NB-1:0];
                            wcnt_d = '0;
                            bw_d   = '0;
                            st_d   = ST_WAIT_BUSY;
                        end
                    end
                    CMD_READ: begin
                        if (payload >= DATA_W'(MAX_BURST)) begin
                            tx_word = '1;
                            err_d   = 1'b1;
                            ecode_d = ERR_BAD_INDEX;
                        end else begin
                            tx_word = rbuf_q[payload[IW-1:0]];
                        end
                    end
                    CMD_READ_REQ: begin
                        if (payload == '0 || payload > DATA_W'(MAX_BURST)) begin
                            err_d   = 1'b1;
                            ecode_d = ERR_BURST_LEN;
                            tx_word = fit32({cmd, ERR_BURST_LEN, 16'h0});
                        end else begin
                            tx_go = 1'b0;
                            if (busy) begin
                                st_d = ST_EXEC;
                            end else begin
                                rdr_d  = 1'b1;
                                nd_d   = payload[5:0];
                                wcnt_d = '0;
                                bw_d   = '0;
                                st_d   = ST_WAIT_BUSY;
                            end
                        end
                    end
                    CMD_COUNT: begin
                        tx_word = cnt_q;
                        cnt_d   = cnt_q + 1'b1;
                    end
                    CMD_CONST: tx_word = DATA_W'(CONST_WORD);
                    CMD_STATUS: begin
                        tx_word = fit32({ovr_q, ecode_q, last_q});
                        err_d   = 1'b0;
                        ecode_d = ERR_NONE;
                        ovr_d   = '0;
                    end
                    default: begin
                        tx_word = '1;
                        err_d   = 1'b1;
                        ecode_d = ERR_BAD_CMD;
                    end
                endcase
            end
            ST_WAIT_BUSY: begin
                bw_d = bw_q + 1'b1;
                if (busy) begin
                    st_d = ST_WAIT_DONE;
                end else if (bw_q == BWW'(BUSY_WAIT - 1)) begin
                    err_d   = 1'b1;
                    ecode_d = ERR_BUSY_TMO;
                    tx_go   = 1'b1;
                    tx_word = fit32({cmd, ERR_BUSY_TMO, 8'h0, wcnt_q});
                    st_d    = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                // a word arriving with busy's falling edge still counts
                if (rd_rdy) begin
                    if (wcnt_q < {2'b00, nd_q}) begin
                        rbuf_we = 1'b1;
                        rbuf_wi = wcnt_q[IW-1:0];
                        wnext   = wcnt_q + 8'd1;
                    end else begin
                        err_d   = 1'b1;
                        ecode_d = ERR_OVERFLOW;
                        code    = ERR_OVERFLOW;
                    end
                end
                wcnt_d = wnext;
                if (!busy) begin
                    if (cmd == CMD_READ_REQ) last_d = wnext;
                    tx_go   = 1'b1;
                    tx_word = fit32({cmd, code, 8'h0, wnext});
                    st_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (tx_done) st_d = ST_RX;
            end
            default: st_d = ST_RX;
        endcase
`ifdef HYPER_BRIDGE_TIMEOUT_EN
        tmo_d = '0;
        if (st_q == ST_RX && bcnt_q != '0 && !rx_valid) begin
            if (tmo_q == 21'(TIMEOUT_CYC - 1)) begin
                bcnt_d  = '0;
                err_d   = 1'b1;
                ecode_d = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + 21'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_RX; frame_q <= '0; bcnt_q <= '0;
            addr_q <= '0; wrd_q <= '0; be_q <= '1; nd_q <= 6'd1;
            wcnt_q <= '0; bw_q <= '0; err_q <= 1'b0; ecode_q <= ERR_NONE;
            cnt_q <= '0; ovr_q <= '0; last_q <= '0;
            rdr_q <= 1'b0; wrr_q <= 1'b0;
        end else begin
            st_q <= st_d; frame_q <= frame_d; bcnt_q <= bcnt_d;
            addr_q <= addr_d; wrd_q <= wrd_d; be_q <= be_d; nd_q <= nd_d;
            wcnt_q <= wcnt_d; bw_q <= bw_d; err_q <= err_d; ecode_q <= ecode_d;
            cnt_q <= cnt_d; ovr_q <= ovr_d; last_q <= last_d;
            rdr_q <= rdr_d; wrr_q <= wrr_d;
        end
    end

`ifdef HYPER_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    // read buffer deliberately survives reset
    always_ff @(posedge clk) begin
        if (rbuf_we && !reset) rbuf_q[rbuf_wi] <= rd_d;
    end

    hyper_bridge_txser #(.DATA_W(DATA_W)) u_txser (
        .clk        (clk),
        .reset      (reset),
        .start_i    (tx_go),
        .word_i     (tx_word),
        .tx_ready_i (tx_ready),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .done_o     (tx_done)
    );

    assign rd_req        = rdr_q;
    assign wr_req        = wrr_q;
    assign addr          = addr_q;
    assign wr_d          = wrd_q;
    assign wr_byte_en    = be_q;
    assign rd_num_dwords = nd_q;
    assign err           = err_q;

endmodule

// File: tb/tb_hyper_cmd_bridge.sv
// tb_hyper_cmd_bridge: directed and random frames against a
// frame-level reference model of the command bridge.
module tb_hyper_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        rd_req, wr_req;
    logic [31:0] addr, wr_d;
    logic [3:0]  wr_byte_en;
    logic [5:0]  rd_num_dwords;
    logic [31:0] rd_d = 32'h0;
    logic        rd_rdy = 1'b0;
    logic        busy = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    hyper_cmd_bridge dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data),
        .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_d(wr_d),
        .wr_byte_en(wr_byte_en), .rd_num_dwords(rd_num_dwords),
        .rd_d(rd_d), .rd_rdy(rd_rdy), .busy(busy), .err(err)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  txq[$];
    int          tx_total = 0;

    int          ctl_mode = 0;
    logic [31:0] supply[$];
    int          wr_seen = 0, rd_seen = 0, both_hi = 0, wide = 0;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic [5:0]  cap_n;
    bit          ctl_idle = 1'b1;
    bit          ctl_rd;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;

    // reference model state
    logic [31:0] m_addr = 0, m_wrd = 0, m_count = 0, m_ovr = 0;
    logic [3:0]  m_be = 4'hF;
    logic [7:0]  m_ecode = 0, m_last = 0;
    logic        m_err = 0;
    logic [31:0] m_buf [8];
    logic [31:0] mw [16];
    int          m_k = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model
    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            txq.push_back(tx_data);
            tx_total++;
            tx_ready = 1'b0;
            repeat (3) @(negedge clk);
            tx_ready = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rd_req === 1'b1 && wr_req === 1'b1) both_hi++;
        if ((rd_req === 1'b1 && prev_rd) || (wr_req === 1'b1 && prev_wr)) wide++;
        prev_rd = (rd_req === 1'b1);
        prev_wr = (wr_req === 1'b1);
    end

    // HyperRAM controller model
    initial forever begin
        @(negedge clk);
        if (wr_req === 1'b1 || rd_req === 1'b1) begin
            ctl_idle = 1'b0;
            ctl_rd = rd_req;
            if (ctl_rd) begin
                rd_seen++;
                cap_n = rd_num_dwords;
            end else begin
                wr_seen++;
                cap_addr = addr; cap_wd = wr_d; cap_be = wr_byte_en;
            end
            if (ctl_mode == 0) begin
                @(negedge clk);
                busy = 1'b1;
                if (ctl_rd) begin
                    while (supply.size() > 0) begin
                        repeat (3) @(negedge clk);
                        rd_d = supply.pop_front();
                        rd_rdy = 1'b1;
                        @(negedge clk);
                        rd_rdy = 1'b0;
                    end
                end else begin
                    repeat (10) @(negedge clk);
                end
                @(negedge clk);
                busy = 1'b0;
            end
            ctl_idle = 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
        send_byte(c);
        for (int i = 3; i >= 0; i--) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(p[8*i +: 8]);
        end
    endtask

    task automatic get_resp(output logic [31:0] r);
        int n;
        n = 0;
        while (txq.size() < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txq.size() < 4) begin
            chk("resp_timeout", 64'(txq.size()), 64'd4);
            r = 32'hx;
            txq.delete();
        end else begin
            for (int i = 0; i < 4; i++) r = {r[23:0], txq.pop_front()};
        end
        repeat (10) @(negedge clk);
    endtask

    // expected response and side effects of one frame
    task automatic model_cmd(input logic [7:0] c, input logic [31:0] p,
                             output logic [31:0] r);
        int got;
        case (c)
            8'h01: begin m_addr = p; r = p; end
            8'h02: begin m_wrd = p; r = p; end
            8'h03: begin
                m_be = (p[3:0] == 0) ? 4'hF : p[3:0];
                if (ctl_mode != 0) begin m_err = 1; m_ecode = 2; end
                r = {8'h03, m_ecode, 16'h0};
            end
            8'h04: begin
                if (p >= 8) begin r = '1; m_err = 1; m_ecode = 5; end
                else r = m_buf[p[2:0]];
            end
            8'h05: begin
                if (p == 0 || p > 8) begin
                    m_err = 1; m_ecode = 4;
                    r = {8'h05, m_ecode, 16'h0};
                end else begin
                    got = (m_k < int'(p)) ? m_k : int'(p);
                    for (int i = 0; i < got; i++) m_buf[i] = mw[i];
                    if (m_k > int'(p)) begin m_err = 1; m_ecode = 3; end
                    m_last = 8'(got);
                    r = {8'h05, m_ecode, 16'(got)};
                end
            end
            8'h06: begin r = m_count; m_count = m_count + 1; end
            8'h07: r = 32'd259;
            8'h08: begin
                r = {m_ovr[15:0], m_ecode, m_last};
                m_err = 0; m_ecode = 0; m_ovr = 0;
            end
            default: begin r = '1; m_err = 1; m_ecode = 1; end
        endcase
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] c,
                          input logic [31:0] p);
        logic [31:0] exp, got;
        model_cmd(c, p, exp);
        send_frame(c, p);
        get_resp(got);
        chk(tag, 64'(got), 64'(exp));
    endtask

    task automatic do_write(input string tag, input logic [31:0] p);
        int w0;
        w0 = wr_seen;
        do_cmd(tag, 8'h03, p);
        chk({tag, "_wr_cnt"}, 64'(wr_seen - w0), 64'd1);
        chk({tag, "_addr"}, 64'(cap_addr), 64'(m_addr));
        chk({tag, "_wd"}, 64'(cap_wd), 64'(m_wrd));
        chk({tag, "_be"}, 64'(cap_be), 64'(m_be));
    endtask

    // k words are offered by the controller for a burst of n
    task automatic do_readreq(input string tag, input int n, input int k);
        int r0;
        bit ok;
        r0 = rd_seen;
        ok = (n >= 1 && n <= 8);
        m_k = ok ? k : 0;
        if (ok) begin
            for (int i = 0; i < k; i++) begin
                mw[i] = $urandom;
                supply.push_back(mw[i]);
            end
        end
        do_cmd(tag, 8'h05, 32'(n));
        chk({tag, "_rd_cnt"}, 64'(rd_seen - r0), ok ? 64'd1 : 64'd0);
        if (ok) chk({tag, "_num"}, 64'(cap_n), 64'(n));
    endtask

    task automatic model_reset();
        m_addr = 0; m_wrd = 0; m_count = 0; m_ovr = 0;
        m_be = 4'hF; m_ecode = 0; m_last = 0; m_err = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int t0, n;
        logic [31:0] r;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_reqs", 64'({rd_req, wr_req}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_wr_d", 64'(wr_d), 64'd0);
        chk("rst_be", 64'(wr_byte_en), 64'hF);
        chk("rst_num", 64'(rd_num_dwords), 64'd1);

        t0 = tx_total;
        do_cmd("addr_100", 8'h01, 32'h0000_0100);
        do_cmd("load_dead", 8'h02, 32'hDEAD_BEEF);
        do_write("write_0", 32'h0);
        chk("tx_bytes_12", 64'(tx_total - t0), 64'd12);

        m_k = 4;
        mw[0] = 32'h11; mw[1] = 32'h22; mw[2] = 32'h33; mw[3] = 32'h44;
        for (int i = 0; i < 4; i++) supply.push_back(mw[i]);
        n = rd_seen;
        do_cmd("rdreq_4", 8'h05, 32'd4);
        chk("rdreq_4_num", 64'(cap_n), 64'd4);
        chk("rdreq_4_cnt", 64'(rd_seen - n), 64'd1);
        do_cmd("read_2", 8'h04, 32'd2);

        do_readreq("rdreq_0", 0, 0);
        do_readreq("rdreq_9", 9, 0);
        chk("err_after_bad_len", 64'(err), 64'd1);
        do_cmd("status_len", 8'h08, 32'h0);
        chk("err_cleared", 64'(err), 64'd0);

        ctl_mode = 1;
        do_write("write_nobusy", 32'h0);
        ctl_mode = 0;
        chk("err_busy_tmo", 64'(err), 64'd1);
        do_cmd("status_tmo", 8'h08, 32'h0);

        // three bytes arrive while the bridge is executing/responding
        model_cmd(8'h06, 32'h0, r);
        send_frame(8'h06, 32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'hA5);
        m_ovr = m_ovr + 3;
        begin
            logic [31:0] g;
            get_resp(g);
            chk("count_0", 64'(g), 64'(r));
        end
        do_cmd("count_1", 8'h06, 32'h0);
        do_cmd("status_ovr", 8'h08, 32'h0);

        // reset while the burst is in WAIT_DONE
        for (int i = 0; i < 4; i++) supply.push_back($urandom);
        send_frame(8'h05, 32'd4);
        n = 0;
        while (busy !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        chk("busy_seen", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        t0 = tx_total;
        repeat (40) @(negedge clk);
        chk("rst_mid_no_tx", 64'(tx_total - t0), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        chk("rst_mid_num", 64'(rd_num_dwords), 64'd1);
        n = 0;
        while (!ctl_idle && n < 500) begin @(negedge clk); n++; end
        chk("ctl_idle", 64'(ctl_idle), 64'd1);
        supply.delete();
        repeat (5) @(negedge clk);
        do_cmd("const", 8'h07, 32'h0);
        do_cmd("count_after_rst", 8'h06, 32'h0);

        do_readreq("rdreq_fill", 8, 8);
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 6))
                0: do_cmd("r_addr", 8'h01, $urandom);
                1: do_cmd("r_load", 8'h02, $urandom);
                2: do_write("r_write", $urandom);
                3: begin
                    n = $urandom_range(0, 10);
                    do_readreq("r_rdreq", n,
                               ($urandom_range(0, 3) == 0) ? n + 1 : n);
                end
                4: do_cmd("r_read", 8'h04, 32'($urandom_range(0, 9)));
                5: do_cmd("r_count", 8'h06, 32'h0);
                default: begin
                    case ($urandom_range(0, 2))
                        0: do_cmd("r_status", 8'h08, 32'h0);
                        1: do_cmd("r_const", 8'h07, $urandom);
                        default: do_cmd("r_badcmd", 8'($urandom_range(9, 255)),
                                        $urandom);
                    endcase
                end
            endcase
            chk("r_err_pin", 64'(err), 64'(m_err));
        end
        do_cmd("final_status", 8'h08, 32'h0);

        chk("req_overlap", 64'(both_hi), 64'd0);
        chk("req_width", 64'(wide), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
